exec_unit_seq: RTL and testbench
================================

# exec_unit_seq

Parametrised execute-stage unit for the pipelined CPU. It is the successor to the current single-width ALU/HiLo datapath. It performs single-cycle logic/arithmetic/shift ops with a registered result, and iterative unsigned multiply and divide that write internal HI/LO registers over WIDTH cycles. A valid/ready handshake lets the pipeline stall while a multi-cycle op is in flight, and a kill input lets the pipeline abort that op on a flush.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be a power of two, at least 8.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  an operation is presented.
- in_ready  output  1  unit can accept this cycle; equals ~busy & ~kill.
- funct  input  6  operation code.
- dataA  input  WIDTH  operand A.
- dataB  input  WIDTH  operand B. For shifts, the shift amount is dataB[$clog2(WIDTH)-1:0].
- kill  input  1  abort any multi-cycle op in flight.
- out_valid  output  1  one-cycle pulse: result and zero are valid.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, qualified by out_valid.
- illegal  output  1  one-cycle pulse, aligned with out_valid, for an unknown funct.
- busy  output  1  a MULTU or DIVU op is iterating.
- done  output  1  one-cycle pulse: HI/LO were just written by MULTU or DIVU.
- div_zero  output  1  one-cycle pulse with done when the completed DIVU had dataB == 0.

## Operation
- Accept when in_valid & in_ready at a clock edge; operands and funct are captured at that edge.
- Single-cycle ops (funct codes):
  - AND 100100, OR 100101.
  - ADD 100000, SUB 100010: wrap modulo 2^WIDTH, no overflow flag.
  - SLT 101010: signed compare; result is 1 or 0.
  - SLL 000000, SRL 000010: logical shifts.
  - MFHI 010000, MFLO 010010: read HI or LO.
  - Each sets result and pulses out_valid; HI/LO are unchanged.
- Unknown funct: result = 0, out_valid = 1, illegal = 1.
- MULTU 011001: unsigned shift-add multiply, one partial product per cycle, WIDTH iterations. On completion HI = product[2W-1:W] and LO = product[W-1:0]. No out_valid.
- DIVU 011011: unsigned restoring divide, one quotient bit per cycle, WIDTH iterations. On completion LO = quotient and HI = remainder. No out_valid.
  - Divide by zero needs no special path. It runs the full WIDTH cycles and yields LO = all ones, HI = dataA, with div_zero asserted.
- State machine IDLE / MUL / DIV:
  - IDLE → MUL or DIV on acceptance of MULTU or DIVU.
  - MUL/DIV → IDLE when the iteration counter reaches 0; HI/LO are written on that edge.
  - MUL/DIV → IDLE on kill; HI/LO keep their prior values and no done pulse is issued.
- kill while IDLE blocks acceptance in that cycle; it has no other effect.
- Reset, including reset mid-operation, takes effect immediately:
  - state goes to IDLE, the counter is cleared, HI = LO = 0;
  - result = 0, and every control output (in_ready excepted) is 0;
  - in_ready = 1 once reset is released.

## Timing
- Let an op be accepted at edge k.
- Single-cycle op: out_valid, result, zero and illegal are valid in the cycle after edge k and drop at edge k+1 unless another op is accepted at k+1. Back-to-back single-cycle ops sustain one per cycle.
- MULTU/DIVU:
  - Iteration steps occur at edges k+1 through k+WIDTH.
  - busy is high from after edge k until edge k+WIDTH; in_ready is low for that span.
  - HI/LO are written at edge k+WIDTH; done (and div_zero if applicable) are high in the following cycle.
  - The earliest next acceptance is edge k+WIDTH+1.
  - An MFHI accepted at that edge returns the new HI after edge k+WIDTH+1.
- kill sampled high at any edge during busy: busy clears at that edge and in_ready returns high in the next cycle.
- result holds its last value between out_valid pulses.

## Structure
- Package exec_pkg holds:
  - localparams for all funct codes;
  - the state enum (IDLE, MUL, DIV);
  - a function computing the single-cycle result.
- Sub-module muldiv_seq owns:
  - the iteration counter ($clog2(WIDTH)+1 bits);
  - the 2W-bit accumulator/remainder and the operand shift registers;
  - the state machine and the kill handling.
  - It exposes start/op/kill inputs and busy/done/hi_next/lo_next outputs.
- The top level holds the HI/LO registers, the result register and the handshake logic.

## Test plan
All scenarios use WIDTH = 32.
- ADD 0x7FFFFFFF + 0x00000001 → 0x80000000 with zero = 0. SUB 5 − 5 → 0 with zero = 1. Both issued back-to-back and answered on consecutive cycles.
- SLT 0xFFFFFFFF vs 0x00000001 → 1. SLL 1 by 31 → 0x80000000. SRL 0x80000000 by dataB = 0x21 → 0x40000000 (only 5 bits of dataB are used).
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy is high for exactly 32 cycles and done pulses once;
  - a following MFHI returns 0xFFFFFFFE and MFLO returns 0x00000001;
  - in_valid held high during busy produces no acceptance.
- DIVU 100 / 7 → LO = 14, HI = 2, div_zero = 0. DIVU 0x12345678 / 0 → LO = 0xFFFFFFFF, HI = 0x12345678, div_zero = 1.
- Sequence MULTU 3 × 4 → done, then DIVU with kill asserted after 10 iterations:
  - busy drops at that edge and no done is issued;
  - MFLO then returns 12.
- reset asserted mid-DIVU: busy, done and out_valid go to 0 asynchronously. After release, MFHI returns 0 and MFLO returns 0. A funct of 111111 pulses illegal with result = 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage unit: funct codes, the multiply/divide
// state type and the single-cycle result function.
package exec_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    // Widest datapath the result function supports.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} md_state_e;

    function automatic logic is_single(input logic [5:0] f);
        case (f)
            F_SLL, F_SRL, F_MFHI, F_MFLO, F_ADD,
            F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Operands arrive zero-extended to MAX_WIDTH; the caller truncates to w bits.
    function automatic logic [MAX_WIDTH-1:0] single_result(
        input logic [5:0]           f,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic [MAX_WIDTH-1:0] hi,
        input logic [MAX_WIDTH-1:0] lo,
        input int unsigned          w
    );
        logic [5:0] sh;
        logic [5:0] msb;
        logic       lt;
        sh  = b[5:0] & 6'(w - 1);
        msb = 6'(w - 1);
        lt  = (a[msb] != b[msb]) ? a[msb] : (a < b);
        case (f)
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_SLT:   return {{(MAX_WIDTH-1){1'b0}}, lt};
            F_SLL:   return a << sh;
            F_SRL:   return a >> sh;
            F_MFHI:  return hi;
            F_MFLO:  return lo;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle,
// producing the next HI/LO values together with a write strobe.
module muldiv_seq
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_op,
    input  logic             i_kill,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_wr,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi_next,
    output logic [WIDTH-1:0] o_lo_next
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    md_state_e          r_state;
    md_state_e          w_state_nx;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   r_opd;
    logic               r_dz;
    logic               r_done;
    logic               r_div_zero;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;

    // MUL: acc = {partial product, remaining multiplier bits}.
    // DIV: acc = {partial remainder, dividend bits / quotient bits shifted in}.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
        w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opd};
        w_acc_step = r_acc;
        if (r_state == ST_MUL)
            w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
        else if (w_trial[WIDTH])
            w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
        else
            w_acc_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        w_last     = (r_cnt == CW'(1));
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nx = i_op ? ST_DIV : ST_MUL;
            default: if (i_kill || w_last) w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opd      <= '0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_done     <= o_wr;
            r_div_zero <= o_wr & r_dz & (r_state == ST_DIV);
            if (r_state == ST_IDLE) begin
                if (i_start) begin
                    r_cnt <= CW'(WIDTH);
                    if (i_op) begin
                        r_acc <= {{WIDTH{1'b0}}, i_a};
                        r_opd <= i_b;
                        r_dz  <= (i_b == '0);
                    end else begin
                        r_acc <= {{WIDTH{1'b0}}, i_b};
                        r_opd <= i_a;
                        r_dz  <= 1'b0;
                    end
                end
            end else if (i_kill) begin
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_wr       = o_busy & w_last & ~i_kill;
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;
    assign o_hi_next  = w_acc_step[2*WIDTH-1:WIDTH];
    assign o_lo_next  = w_acc_step[WIDTH-1:0];

endmodule

// File: rtl/exec_unit_seq.sv
// Execute-stage unit: registered single-cycle ALU result, HI/LO registers fed by the
// iterative multiply/divide engine, and the valid/ready/kill handshake.
module exec_unit_seq
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             kill,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic             r_illegal;
    logic             w_accept;
    logic             w_is_md;
    logic             w_busy;
    logic             w_wr;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic [WIDTH-1:0] w_alu;

    assign in_ready = ~w_busy & ~kill;
    assign w_accept = in_valid & in_ready;
    assign w_is_md  = (funct == F_MULTU) || (funct == F_DIVU);
    assign w_alu    = WIDTH'(single_result(funct, MAX_WIDTH'(dataA), MAX_WIDTH'(dataB),
                                           MAX_WIDTH'(r_hi), MAX_WIDTH'(r_lo), WIDTH));

    muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst_n      (reset),
        .i_start    (w_accept & w_is_md),
        .i_op       (funct == F_DIVU),
        .i_kill     (kill),
        .i_a        (dataA),
        .i_b        (dataB),
        .o_busy     (w_busy),
        .o_wr       (w_wr),
        .o_done     (done),
        .o_div_zero (div_zero),
        .o_hi_next  (w_hi_next),
        .o_lo_next  (w_lo_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_hi <= w_hi_next;
                r_lo <= w_lo_next;
            end
            r_out_valid <= w_accept & ~w_is_md;
            r_illegal   <= w_accept & ~w_is_md & ~is_single(funct);
            if (w_accept && !w_is_md)
                r_result <= w_alu;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_out_valid & (r_result == '0);
    assign illegal   = r_illegal;
    assign busy      = w_busy;

endmodule

// File: tb/tb_exec_unit_seq.sv
// Directed plus randomized checks of exec_unit_seq (WIDTH = 32) against a behavioural
// model of the ALU and of the HI/LO results of multiply and divide.
module tb_exec_unit_seq;

    localparam int W = 32;
    localparam logic [5:0] OP_SLL = 6'b000000, OP_SRL = 6'b000010, OP_MFHI = 6'b010000;
    localparam logic [5:0] OP_MFLO = 6'b010010, OP_MULTU = 6'b011001, OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_ADD = 6'b100000, OP_SUB = 6'b100010, OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR = 6'b100101, OP_SLT = 6'b101010;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, kill;
    logic [5:0]   funct;
    logic [W-1:0] dataA, dataB;
    logic         in_ready, out_valid, zero, illegal, busy, done, div_zero;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_err    = 0;
    logic [W-1:0] m_hi, m_lo;

    exec_unit_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .dataA(dataA), .dataB(dataB), .kill(kill),
        .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic legal(input logic [5:0] f);
        return f inside {OP_SLL, OP_SRL, OP_MFHI, OP_MFLO, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [5:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (f)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL:  return a << (b % 32);
            OP_SRL:  return a >> (b % 32);
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return '0;
        endcase
    endfunction

    task automatic single(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] e;
        e = ref_alu(f, a, b);
        in_valid = 1'b1; funct = f; dataA = a; dataB = b;
        cyc();
        in_valid = 1'b0;
        chk1({tag, " out_valid"}, out_valid, 1'b1);
        chk ({tag, " result"}, result, e);
        chk1({tag, " zero"}, zero, e == '0);
        chk1({tag, " illegal"}, illegal, !legal(f));
    endtask

    // kill_at = number of completed iterations before kill is sampled (0: no kill)
    task automatic md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit hold_valid, input int kill_at);
        int n;
        logic [2*W-1:0] prod;
        n = 0;
        in_valid = 1'b1; funct = f; dataA = a; dataB = b;
        cyc();
        if (hold_valid) funct = OP_ADD;
        else in_valid = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            chk1({tag, " in_ready busy"}, in_ready, 1'b0);
            chk1({tag, " out_valid busy"}, out_valid, 1'b0);
            n++;
            if (kill_at != 0 && n == kill_at + 1) kill = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        if (kill_at != 0) begin
            chk({tag, " busy cycles"}, 32'(n), 32'(kill_at + 1));
            chk1({tag, " done kill"}, done, 1'b0);
            chk1({tag, " in_ready kill"}, in_ready, 1'b0);
            kill = 1'b0;
            #1;
            chk1({tag, " in_ready after kill"}, in_ready, 1'b1);
            cyc();
            chk1({tag, " no done"}, done, 1'b0);
        end else begin
            chk({tag, " busy cycles"}, 32'(n), 32'(W));
            chk1({tag, " done"}, done, 1'b1);
            chk1({tag, " div_zero"}, div_zero, (f == OP_DIVU) && (b == '0));
            if (f == OP_MULTU) begin
                prod = 64'(a) * 64'(b);
                m_hi = prod[2*W-1:W];
                m_lo = prod[W-1:0];
            end else if (b == '0) begin
                m_lo = '1;
                m_hi = a;
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
            cyc();
            chk1({tag, " done pulse"}, done, 1'b0);
            chk1({tag, " div_zero pulse"}, div_zero, 1'b0);
        end
    endtask

    initial begin
        logic [5:0] rf;
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; funct = '0; dataA = '0; dataB = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) cyc();
        chk1("rst out_valid", out_valid, 1'b0);
        chk ("rst result", result, '0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst illegal", illegal, 1'b0);
        chk1("rst div_zero", div_zero, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk1("rst in_ready", in_ready, 1'b1);

        // back-to-back ADD then SUB
        in_valid = 1'b1; funct = OP_ADD; dataA = 32'h7FFF_FFFF; dataB = 32'h1;
        cyc();
        funct = OP_SUB; dataA = 32'd5; dataB = 32'd5;
        chk1("add ov", out_valid, 1'b1);
        chk ("add res", result, 32'h8000_0000);
        chk1("add zero", zero, 1'b0);
        cyc();
        in_valid = 1'b0;
        chk1("sub ov", out_valid, 1'b1);
        chk ("sub res", result, 32'h0);
        chk1("sub zero", zero, 1'b1);
        cyc();
        chk1("ov drops", out_valid, 1'b0);
        chk ("result holds", result, 32'h0);

        single("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1);
        single("sll", OP_SLL, 32'h1, 32'd31);
        single("srl", OP_SRL, 32'h8000_0000, 32'h21);

        md("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        single("mfhi max", OP_MFHI, '0, '0);
        chk("mfhi max const", result, 32'hFFFF_FFFE);
        single("mflo max", OP_MFLO, '0, '0);
        chk("mflo max const", result, 32'h1);

        md("divu 100/7", OP_DIVU, 32'd100, 32'd7, 1'b0, 0);
        single("mflo 100/7", OP_MFLO, '0, '0);
        chk("quot 100/7", result, 32'd14);
        single("mfhi 100/7", OP_MFHI, '0, '0);
        chk("rem 100/7", result, 32'd2);

        md("divu by0", OP_DIVU, 32'h1234_5678, 32'h0, 1'b0, 0);
        single("mflo by0", OP_MFLO, '0, '0);
        single("mfhi by0", OP_MFHI, '0, '0);
        chk("rem by0", result, 32'h1234_5678);

        md("multu 3x4", OP_MULTU, 32'd3, 32'd4, 1'b0, 0);
        md("divu killed", OP_DIVU, 32'd1000, 32'd3, 1'b0, 10);
        single("mflo after kill", OP_MFLO, '0, '0);
        chk("mflo 12", result, 32'd12);

        for (int i = 0; i < 24; i++) begin
            rf = 6'($urandom_range(0, 63));
            if (rf == OP_MULTU || rf == OP_DIVU) rf = OP_ADD;
            if (i % 3 == 0) rf = OP_SLT;
            single("rand single", rf, $urandom, (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 40)));
        end
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                md("rand multu", OP_MULTU, $urandom, $urandom, 1'b0, 0);
            else
                md("rand divu", OP_DIVU, $urandom, (i == 5) ? 32'($urandom_range(1, 300)) : $urandom, 1'b0, 0);
            single("rand mfhi", OP_MFHI, '0, '0);
            single("rand mflo", OP_MFLO, '0, '0);
        end

        // reset in the middle of a divide
        in_valid = 1'b1; funct = OP_DIVU; dataA = 32'd999; dataB = 32'd9;
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        chk1("pre-rst busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async rst busy", busy, 1'b0);
        chk1("async rst done", done, 1'b0);
        chk1("async rst out_valid", out_valid, 1'b0);
        chk ("async rst result", result, '0);
        m_hi = '0; m_lo = '0;
        @(negedge clk) rst_n = 1'b1;
        single("mfhi after rst", OP_MFHI, 32'h55, 32'h66);
        single("mflo after rst", OP_MFLO, 32'h55, 32'h66);
        single("illegal 3f", 6'b111111, 32'hDEAD_BEEF, 32'h1);
        cyc();
        chk1("illegal drops", illegal, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
